vermibridge: RTL and testbench

- Byte-stream-to-Vermibus initiator: a host debug/loader bridge.
- Consumes command bytes from a UART receive stream and issues single-word read/write transactions on a Vermibus data bus as initiator (read_write_request modport).
- Returns status/data bytes on a UART transmit stream.
- Lets a host load RAM and poke timer/UART registers without the CPU; sits beside the CPU on the shared data-bus decode.

---
 rtl/vermibridge_pkg.sv | 18 +
 rtl/vermibridge_if.sv | 22 ++
 rtl/vermibridge.sv | 129 ++++++++++++
 tb/tb_vermibridge.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vermibridge_pkg.sv
// Shared constants and small types for the byte-stream to Vermibus bridge.
package vermibridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_BUS  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    typedef logic [1:0] byte_idx_t;
    typedef logic [2:0] resp_cnt_t;

endpackage

// File: rtl/vermibridge_if.sv
// Vermibus single-word data bus: initiator and target views.
interface vermibridge_if;

    logic        valid;
    logic [31:0] address;
    logic [3:0]  wstrobe;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    modport read_write_request (
        output valid, address, wstrobe, wdata,
        input  rdata, ready, irq
    );

    modport read_write_respond (
        input  valid, address, wstrobe, wdata,
        output rdata, ready, irq
    );

endinterface

// File: rtl/vermibridge.sv
// Host bridge: rx command bytes -> one Vermibus read/write -> tx status/data bytes.
// Bus access starts the cycle after the last command byte; rx is stalled during BUS and RESP.
module vermibridge
    import vermibridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    vermibridge_if.read_write_request  bus,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    byte_idx_t   idx;
    resp_cnt_t   resp_cnt;
    logic        is_write;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rsp_sh;
    logic [31:0] wait_cnt;
    logic        rx_fire;
    logic        timeout_hit;

    assign rx_ready = reset && (state == ST_IDLE || state == ST_ADDR || state == ST_DATA);
    assign rx_fire  = rx_valid && rx_ready;
    assign busy     = reset && (state != ST_IDLE);

    // Bus outputs decode straight from held registers, so they cannot move during a stall.
    assign bus.valid   = (state == ST_BUS);
    assign bus.address = {addr_q[31:2], 2'b00};
    assign bus.wstrobe = (state == ST_BUS && is_write) ? 4'b1111 : 4'b0000;
    assign bus.wdata   = wdata_q;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);

    wire unused_bits = ^{bus.irq, addr_q[1:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            resp_cnt <= '0;
            is_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rsp_sh   <= '0;
            wait_cnt <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_fire) begin
                        if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                            is_write <= (rx_data == OP_WRITE);
                            idx      <= '0;
                            state    <= ST_ADDR;
                        end else begin
                            tx_data  <= NAK;
                            tx_valid <= 1'b1;
                            resp_cnt <= 3'd1;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_fire) begin
                        addr_q[{idx, 3'b000} +: 8] <= rx_data;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            wait_cnt <= '0;
                            state    <= is_write ? ST_DATA : ST_BUS;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_fire) begin
                        wdata_q[{idx, 3'b000} +: 8] <= rx_data;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            wait_cnt <= '0;
                            state    <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (bus.ready) begin
                        rsp_sh   <= bus.rdata;
                        tx_data  <= ACK;
                        tx_valid <= 1'b1;
                        resp_cnt <= is_write ? 3'd1 : 3'd5;
                        state    <= ST_RESP;
                    end else if (timeout_hit) begin
                        tx_data  <= NAK;
                        tx_valid <= 1'b1;
                        resp_cnt <= 3'd1;
                        state    <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                ST_RESP: begin
                    if (tx_ready) begin
                        if (resp_cnt == 3'd1) begin
                            tx_valid <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            // Read data drains LSB first straight behind the ACK.
                            tx_data  <= rsp_sh[7:0];
                            rsp_sh   <= {8'h00, rsp_sh[31:8]};
                            resp_cnt <= resp_cnt - 3'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vermibridge.sv
// Randomized bench for vermibridge against a command-level reference model and a RAM-like bus target.
module tb_vermibridge;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
    } btx_t;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    vermibridge_if bif ();
    assign bif.irq = 1'b0;

    vermibridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bif),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expectation side (model) and observation side (monitors).
    logic [7:0]  exp_tx[$];
    logic [7:0]  got_tx[$];
    btx_t        exp_bus[$];
    btx_t        got_bus[$];
    logic [31:0] mmem[logic [31:0]];
    logic [31:0] tmem[logic [31:0]];

    int   stall_req = 0;
    bit   tx_rand = 0;
    logic tx_ready_force = 1'b1;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    function automatic void model(input logic [7:0] op, input logic [31:0] a,
                                  input logic [31:0] d, input int stall);
        logic [31:0] aa;
        logic [31:0] rd;
        aa = {a[31:2], 2'b00};
        if (op == 8'h57 && stall >= 0) begin
            exp_bus.push_back('{aa, 4'hF, d});
            mmem[aa] = d;
            exp_tx.push_back(8'h06);
        end else if (op == 8'h52 && stall >= 0) begin
            exp_bus.push_back('{aa, 4'h0, 32'h0});
            rd = mmem.exists(aa) ? mmem[aa] : dflt(aa);
            exp_tx.push_back(8'h06);
            for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
        end else begin
            exp_tx.push_back(8'h15);
        end
    endfunction

    // Bus target, tx sink and protocol monitors, all sampled on the falling edge.
    int          vcyc = 0;
    int          last_vrun = 0;
    logic [31:0] mon_a, prev_a, prev_d;
    logic [3:0]  prev_s;
    logic [7:0]  prev_tx;
    bit          tx_wait = 0;

    always @(negedge clk) begin
        tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : tx_ready_force;
        if (reset && bif.valid) begin
            bif.ready = (stall_req >= 0) && (vcyc >= stall_req);
            mon_a = bif.address;
            bif.rdata = tmem.exists(mon_a) ? tmem[mon_a] : dflt(mon_a);
            if (vcyc > 0) begin
                chk("stall_addr", bif.address, prev_a);
                chk("stall_strb", bif.wstrobe, prev_s);
                chk("stall_wdata", bif.wdata, prev_d);
            end
            prev_a = bif.address;
            prev_s = bif.wstrobe;
            prev_d = bif.wdata;
            if (bif.ready) begin
                got_bus.push_back('{bif.address, bif.wstrobe, bif.wdata});
                if (bif.wstrobe == 4'hF) tmem[mon_a] = bif.wdata;
            end
            vcyc++;
        end else begin
            bif.ready = 1'b0;
            bif.rdata = $urandom;
            if (vcyc > 0) last_vrun = vcyc;
            vcyc = 0;
        end
        if (reset && tx_valid) begin
            if (tx_wait) chk("tx_hold", tx_data, prev_tx);
            if (tx_ready) got_tx.push_back(tx_data);
            tx_wait = !tx_ready;
            prev_tx = tx_data;
        end else begin
            tx_wait = 0;
        end
        if (reset) chk("rx_ready_rule", rx_ready, !bif.valid && !tx_valid);
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rx_ready) break;
        end
        chk("rx_accept", rx_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                       input int stall, input bit modeled, input bit idle_after);
        stall_req = stall;
        if (modeled) model(op, a, d, stall);
        send_byte(op);
        if (op == 8'h57 || op == 8'h52)
            for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        if (op == 8'h57)
            for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
        if (idle_after) rx_valid = 1'b0;
    endtask

    task automatic finish_cmd();
        btx_t e, g;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy && got_tx.size() >= exp_tx.size()) break;
        end
        chk("idle_after_cmd", busy, 1'b0);
        chk("tx_count", got_tx.size(), exp_tx.size());
        while (exp_tx.size() > 0 && got_tx.size() > 0)
            chk("tx_byte", got_tx.pop_front(), exp_tx.pop_front());
        chk("bus_count", got_bus.size(), exp_bus.size());
        while (exp_bus.size() > 0 && got_bus.size() > 0) begin
            e = exp_bus.pop_front();
            g = got_bus.pop_front();
            chk("bus_addr", g.a, e.a);
            chk("bus_strb", g.s, e.s);
            if (e.s == 4'hF) chk("bus_wdata", g.d, e.d);
        end
        exp_tx.delete();
        got_tx.delete();
        exp_bus.delete();
        got_bus.delete();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pool[4] = '{32'h10, 32'h14, 32'h8000_0004, 32'h100};

    initial begin
        logic [7:0]  op;
        logic [31:0] a;
        int          st;

        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", bif.valid, 1'b0);
        chk("rst_addr", bif.address, 32'h0);
        chk("rst_strb", bif.wstrobe, 4'h0);
        chk("rst_wdata", bif.wdata, 32'h0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_rx_ready", rx_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Write then read back the same RAM word.
        cmd(8'h57, 32'h10, 32'hDEAD_BEEF, 0, 1, 1);
        finish_cmd();
        cmd(8'h52, 32'h10, 32'h0, 0, 1, 1);
        finish_cmd();

        // Unaligned read with a 3-cycle stall.
        cmd(8'h52, 32'h8000_0007, 32'h0, 3, 1, 1);
        finish_cmd();

        // Unknown opcode with the sink stalled for 5 cycles.
        tx_ready_force = 1'b0;
        model(8'h41, 32'h0, 32'h0, 0);
        send_byte(8'h41);
        rx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("nak_tx_valid", tx_valid, 1'b1);
            chk("nak_tx_data", tx_data, 8'h15);
            chk("nak_rx_ready", rx_ready, 1'b0);
        end
        @(posedge clk);
        #1 tx_ready_force = 1'b1;
        finish_cmd();

        // Timeout: never ready, then a normal read.
        cmd(8'h57, 32'h20, 32'h1234_5678, -1, 1, 1);
        finish_cmd();
        chk("timeout_valid_run", last_vrun, 8);
        cmd(8'h52, 32'h20, 32'h0, 1, 1, 1);
        finish_cmd();

        // Ready arriving in the last cycle before the timeout still completes.
        cmd(8'h57, 32'h24, 32'hCAFE_F00D, 7, 1, 1);
        finish_cmd();

        // Reset pulse during the bus phase.
        cmd(8'h52, 32'h30, 32'h0, -1, 0, 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bif.valid) break;
        end
        chk("mid_valid_seen", bif.valid, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        chk("mid_valid", bif.valid, 1'b0);
        chk("mid_tx_valid", tx_valid, 1'b0);
        chk("mid_busy", busy, 1'b0);
        repeat (20) @(negedge clk);
        finish_cmd();

        // Two writes streamed back to back.
        cmd(8'h57, 32'h40, 32'h1111_2222, 0, 1, 0);
        cmd(8'h57, 32'h44, 32'h3333_4444, 0, 1, 1);
        finish_cmd();

        // Random commands with a randomly stalling sink.
        tx_rand = 1;
        for (int n = 0; n < 40; n++) begin
            a  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
            st = int'($urandom_range(0, 7));
            if ($urandom_range(0, 11) == 0) st = -1;
            case ($urandom_range(0, 9))
                0: begin
                    op = 8'($urandom_range(0, 255));
                    if (op == 8'h57 || op == 8'h52) op = 8'h00;
                end
                1, 2, 3, 4: op = 8'h57;
                default: op = 8'h52;
            endcase
            cmd(op, a, $urandom, st, 1, 1);
            finish_cmd();
        end
        tx_rand = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
